prng_arbiter: RTL and testbench
===============================

// Module: prng_arbiter
// PURPOSE
// - Shares the single Trivium PRNG between two polynomial generators, e.g. uniform A-sampler (req 0) and noise sampler (req 1).
// - Each requester holds a lock request for a whole job, including its reseed and all of its 128-bit draws.
// - Arbitration is round-robin. The owner's seed/reseed/rdi_ready go to the PRNG; PRNG responses go back to the owner only.
// - Any response still outstanding when ownership ends is drained and discarded before the next grant.
// PARAMETERS
// - SEED_W  256  PRNG seed width.
// - DATA_W  128  PRNG output block width.
// PORTS
// - clk          in   1       clock
// - rst          in   1       synchronous reset, active-high
// - req          in   2       lock request per requester; held high for the whole job
// - gnt          out  2       one-hot grant, registered
// - r0_seed      in   SEED_W  requester 0 seed
// - r1_seed      in   SEED_W  requester 1 seed
// - r_reseed     in   2       reseed pulse per requester
// - r_reseed_ack out  2       reseed ack per requester
// - r_rdi_ready  in   2       draw-request pulse per requester
// - r_rdi_valid  out  2       draw-valid per requester
// - r_rdi_data   out  DATA_W  PRNG data, broadcast to both requesters (qualify with r_rdi_valid)
// - seed         out  SEED_W  seed to PRNG, registered
// - reseed       out  1       reseed pulse to PRNG, registered
// - reseed_ack   in   1       PRNG reseed ack
// - rdi_ready    out  1       draw request to PRNG, registered
// - rdi_valid    in   1       PRNG data valid
// - rdi_data     in   DATA_W  PRNG data
// - protocol_err out  1       sticky error flag; cleared only by rst
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, rs_pend=rd_pend=0, last=1 (so req 0 wins the first tie).
//   rst mid-job aborts immediately; PRNG responses arriving after reset are ignored.
// - States:
//   IDLE:  if req!=0, owner <= round-robin pick (favour !last on tie); last <= owner; gnt[owner] <= 1; go to OWN.
//   OWN:   if req[owner]==0: gnt <= 0; go to IDLE if rs_pend==0 and rd_pend==0, else go to DRAIN.
//   DRAIN: go to IDLE once every pending flag has cleared.
// - IDLE always spends at least one cycle between owners, so gnt never switches directly from one requester to the other.
// - Forwarding in OWN, 1-cycle latency:
//   r_reseed[owner] -> seed <= r{owner}_seed, reseed pulse, rs_pend <= 1.
//   r_rdi_ready[owner] -> rdi_ready pulse, rd_pend <= 1.
// - Responses are combinational, 0-cycle:
//   r_reseed_ack[o] = reseed_ack & rs_pend & state==OWN & owner==o.
//   r_rdi_valid[o] = rdi_valid & rd_pend & state==OWN & owner==o.
// - reseed_ack clears rs_pend. rdi_valid clears rd_pend. Either may arrive in the same cycle it is forwarded: no.
//   Each may arrive at the earliest in the cycle after the pulse, and the clear takes effect in that cycle.
// - In DRAIN, responses clear the pending flags but are not forwarded.
// - Dropped requests (each sets protocol_err):
//   - reseed/rdi_ready pulse from the non-owner, or in IDLE/DRAIN.
//   - a new reseed while rs_pend=1, or a new rdi_ready while rd_pend=1.
//   - reseed and rdi_ready from the owner in the same cycle: reseed wins, rdi_ready dropped.
// - Responses with no matching pending flag are ignored; protocol_err is not set.
// - seed holds its last value between reseeds. rdi_data passes straight through, unregistered.
// TESTING
// - T1: after reset, req=01. Next cycle gnt=01. r_reseed[0] -> reseed=1 one cycle later with seed=r0_seed.
//   PRNG ack at +3 -> r_reseed_ack[0]=1 in the same cycle, r_reseed_ack[1]=0.
// - T2: req=11 from IDLE after reset -> gnt=01. Drop req[0] -> gnt=00, then one IDLE cycle, then gnt=10. Repeat -> gnt=01 (round-robin).
// - T3: owner 0 issues rdi_ready, then drops req before rdi_valid -> state DRAIN, gnt=00.
//   rdi_valid arrives with data 0xA5.. -> r_rdi_valid=00; next cycle IDLE; pending req[1] granted after that.
// - T4: non-owner 1 pulses r_rdi_ready while 0 owns -> rdi_ready stays 0, protocol_err=1 and remains 1 until rst.
// - T5: owner raises r_reseed and r_rdi_ready in the same cycle -> only reseed forwarded, rd_pend=0, protocol_err=1.
// - T6: rst asserted with rd_pend=1 -> next cycle gnt=00, rdi_ready=0, state IDLE. A late rdi_valid is not forwarded.

Source files
------------

// File: rtl/prng_arbiter.sv
// Round-robin lock arbiter sharing one Trivium PRNG between two requesters.
// The owner's seed/reseed/draw requests are forwarded with one cycle of latency.
// Responses route back to the owner with no added latency, and are drained when ownership ends.
module prng_arbiter #(
   parameter int SEED_W = 256,
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req,
   output logic [1:0]        gnt,
   input  logic [SEED_W-1:0] r0_seed,
   input  logic [SEED_W-1:0] r1_seed,
   input  logic [1:0]        r_reseed,
   output logic [1:0]        r_reseed_ack,
   input  logic [1:0]        r_rdi_ready,
   output logic [1:0]        r_rdi_valid,
   output logic [DATA_W-1:0] r_rdi_data,
   output logic [SEED_W-1:0] seed,
   output logic              reseed,
   input  logic              reseed_ack,
   output logic              rdi_ready,
   input  logic              rdi_valid,
   input  logic [DATA_W-1:0] rdi_data,
   output logic              protocol_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [SEED_W-1:0] seed_q, seed_d;
   logic              reseed_q, reseed_d;
   logic              rdi_ready_q, rdi_ready_d;
   logic              rs_pend_q, rs_pend_d;
   logic              rd_pend_q, rd_pend_d;
   logic              err_q, err_d;

   logic              pick;
   logic              other;
   logic [1:0]        own_mask;

   assign other    = ~owner_q;
   assign own_mask = owner_q ? 2'b10 : 2'b01;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      gnt_d       = gnt_q;
      seed_d      = seed_q;
      reseed_d    = 1'b0;
      rdi_ready_d = 1'b0;
      rs_pend_d   = rs_pend_q & ~reseed_ack;
      rd_pend_d   = rd_pend_q & ~rdi_valid;
      err_d       = err_q;
      pick        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if ((r_reseed != 2'b00) || (r_rdi_ready != 2'b00)) err_d = 1'b1;
            if (req != 2'b00) begin
               // On a tie, the requester that was not served last wins.
               pick    = (req == 2'b11) ? ~last_q : req[1];
               owner_d = pick;
               last_d  = pick;
               gnt_d   = pick ? 2'b10 : 2'b01;
               state_d = ST_OWN;
            end
         end
         ST_OWN: begin
            if (r_reseed[other] || r_rdi_ready[other]) err_d = 1'b1;
            if (r_reseed[owner_q]) begin
               if (rs_pend_q) begin
                  err_d = 1'b1;
               end else begin
                  seed_d    = owner_q ? r1_seed : r0_seed;
                  reseed_d  = 1'b1;
                  rs_pend_d = 1'b1;
               end
            end
            // A simultaneous reseed takes priority, so the draw is dropped.
            if (r_rdi_ready[owner_q]) begin
               if (r_reseed[owner_q] || rd_pend_q) begin
                  err_d = 1'b1;
               end else begin
                  rdi_ready_d = 1'b1;
                  rd_pend_d   = 1'b1;
               end
            end
            if (!req[owner_q]) begin
               gnt_d   = 2'b00;
               state_d = (rs_pend_d || rd_pend_d) ? ST_DRAIN : ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if ((r_reseed != 2'b00) || (r_rdi_ready != 2'b00)) err_d = 1'b1;
            if (!rs_pend_d && !rd_pend_d) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q     <= ST_IDLE;
         owner_q     <= 1'b0;
         last_q      <= 1'b1;
         gnt_q       <= 2'b00;
         seed_q      <= '0;
         reseed_q    <= 1'b0;
         rdi_ready_q <= 1'b0;
         rs_pend_q   <= 1'b0;
         rd_pend_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         gnt_q       <= gnt_d;
         seed_q      <= seed_d;
         reseed_q    <= reseed_d;
         rdi_ready_q <= rdi_ready_d;
         rs_pend_q   <= rs_pend_d;
         rd_pend_q   <= rd_pend_d;
         err_q       <= err_d;
      end
   end

   // Responses reach only the current owner; in DRAIN they are swallowed.
   assign r_reseed_ack = (reseed_ack && rs_pend_q && (state_q == ST_OWN)) ? own_mask : 2'b00;
   assign r_rdi_valid  = (rdi_valid && rd_pend_q && (state_q == ST_OWN)) ? own_mask : 2'b00;
   assign r_rdi_data   = rdi_data;

   assign gnt          = gnt_q;
   assign seed         = seed_q;
   assign reseed       = reseed_q;
   assign rdi_ready    = rdi_ready_q;
   assign protocol_err = err_q;

endmodule

// File: tb/tb_prng_arbiter.sv
// Bench for prng_arbiter: directed scenarios with literal expectations, then
// randomized traffic, with every cycle compared against a behavioural model.
module tb_prng_arbiter;

   localparam int SEED_W = 256;
   localparam int DATA_W = 128;
   localparam logic [SEED_W-1:0] SEED0 = {8{32'h1234_5678}};
   localparam logic [SEED_W-1:0] SEED1 = {8{32'hCAFE_F00D}};
   localparam logic [DATA_W-1:0] DATA_A5 = {16{8'hA5}};

   logic              clk;
   logic              rst;
   logic [1:0]        req;
   logic [1:0]        gnt;
   logic [SEED_W-1:0] r0_seed;
   logic [SEED_W-1:0] r1_seed;
   logic [1:0]        r_reseed;
   logic [1:0]        r_reseed_ack;
   logic [1:0]        r_rdi_ready;
   logic [1:0]        r_rdi_valid;
   logic [DATA_W-1:0] r_rdi_data;
   logic [SEED_W-1:0] seed;
   logic              reseed;
   logic              reseed_ack;
   logic              rdi_ready;
   logic              rdi_valid;
   logic [DATA_W-1:0] rdi_data;
   logic              protocol_err;

   prng_arbiter #(.SEED_W(SEED_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt),
      .r0_seed(r0_seed), .r1_seed(r1_seed),
      .r_reseed(r_reseed), .r_reseed_ack(r_reseed_ack),
      .r_rdi_ready(r_rdi_ready), .r_rdi_valid(r_rdi_valid), .r_rdi_data(r_rdi_data),
      .seed(seed), .reseed(reseed), .reseed_ack(reseed_ack),
      .rdi_ready(rdi_ready), .rdi_valid(rdi_valid), .rdi_data(rdi_data),
      .protocol_err(protocol_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Model: who holds the lock (-1 = nobody), who was served last, and which
   // responses are still owed by the PRNG.
   int                m_holder = -1;
   int                m_last   = 1;
   bit                m_rs     = 1'b0;
   bit                m_rd     = 1'b0;
   logic [SEED_W-1:0] m_seed   = '0;
   bit                m_reseed = 1'b0;
   bit                m_rdi_ready = 1'b0;
   bit                m_err    = 1'b0;

   bit saw_rs, saw_rd;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit was_free, new_rs, new_rd;
      int o;
      if (rst) begin
         m_holder = -1; m_last = 1; m_rs = 1'b0; m_rd = 1'b0; m_seed = '0;
         m_reseed = 1'b0; m_rdi_ready = 1'b0; m_err = 1'b0;
         return;
      end
      was_free = (m_holder < 0) && !m_rs && !m_rd;
      new_rs = 1'b0;
      new_rd = 1'b0;
      if (m_holder >= 0) begin
         o = m_holder;
         if (r_reseed[1-o] || r_rdi_ready[1-o]) m_err = 1'b1;
         if (r_reseed[o]) begin
            if (m_rs) m_err = 1'b1;
            else begin
               new_rs = 1'b1;
               m_seed = (o == 1) ? r1_seed : r0_seed;
            end
         end
         if (r_rdi_ready[o]) begin
            if (r_reseed[o] || m_rd) m_err = 1'b1;
            else new_rd = 1'b1;
         end
      end else if ((r_reseed != 2'b00) || (r_rdi_ready != 2'b00)) begin
         m_err = 1'b1;
      end
      m_rs = (m_rs && !reseed_ack) || new_rs;
      m_rd = (m_rd && !rdi_valid) || new_rd;
      m_reseed = new_rs;
      m_rdi_ready = new_rd;
      if (m_holder >= 0) begin
         if (!req[m_holder]) m_holder = -1;
      end else if (was_free && (req != 2'b00)) begin
         if (req == 2'b11) m_holder = (m_last == 1) ? 0 : 1;
         else m_holder = req[1] ? 1 : 0;
         m_last = m_holder;
      end
   endtask

   task automatic compare_model();
      logic [1:0] exp_gnt, exp_ack, exp_val;
      exp_gnt = (m_holder >= 0) ? 2'(1 << m_holder) : 2'b00;
      exp_ack = (reseed_ack && m_rs && m_holder >= 0) ? 2'(1 << m_holder) : 2'b00;
      exp_val = (rdi_valid && m_rd && m_holder >= 0) ? 2'(1 << m_holder) : 2'b00;
      check("gnt", gnt, exp_gnt);
      check("reseed", reseed, m_reseed);
      check("rdi_ready", rdi_ready, m_rdi_ready);
      check("seed", seed, m_seed);
      check("protocol_err", protocol_err, m_err);
      check("r_reseed_ack", r_reseed_ack, exp_ack);
      check("r_rdi_valid", r_rdi_valid, exp_val);
      check("r_rdi_data", r_rdi_data, rdi_data);
   endtask

   // One clock: compare mid-cycle, advance the model on the edge, return 1 time unit later.
   task automatic step();
      @(negedge clk);
      if (chk_en) compare_model();
      saw_rs = reseed;
      saw_rd = rdi_ready;
      @(posedge clk);
      model_step();
      #1;
   endtask

   initial begin
      int rs_cnt, rd_cnt;
      rs_cnt = 0;
      rd_cnt = 0;
      rst = 1'b1; req = 2'b00; r0_seed = SEED0; r1_seed = SEED1;
      r_reseed = 2'b00; r_rdi_ready = 2'b00; reseed_ack = 1'b0; rdi_valid = 1'b0;
      rdi_data = '0;
      step();
      step();
      rst = 1'b0;
      chk_en = 1'b1;
      check("reset_gnt", gnt, 2'b00);
      check("reset_err", protocol_err, 1'b0);
      check("reset_seed", seed, '0);

      // Owner 0 reseeds; PRNG acks three cycles after the request.
      req = 2'b01;
      step();
      check("t1_gnt", gnt, 2'b01);
      r_reseed = 2'b01;
      step();
      r_reseed = 2'b00;
      check("t1_reseed", reseed, 1'b1);
      check("t1_seed", seed, SEED0);
      step();
      step();
      reseed_ack = 1'b1;
      #1;
      check("t1_ack", r_reseed_ack, 2'b01);
      step();
      reseed_ack = 1'b0;

      // Owner 0 draws then releases early; the late data is drained, then 1 gets the lock.
      r_rdi_ready = 2'b01;
      step();
      r_rdi_ready = 2'b00;
      check("t3_rdi_ready", rdi_ready, 1'b1);
      req = 2'b10;
      step();
      check("t3_drain_gnt", gnt, 2'b00);
      rdi_data = DATA_A5;
      rdi_valid = 1'b1;
      #1;
      check("t3_no_fwd", r_rdi_valid, 2'b00);
      check("t3_data", r_rdi_data, DATA_A5);
      step();
      rdi_valid = 1'b0;
      check("t3_idle_gnt", gnt, 2'b00);
      step();
      check("t3_gnt1", gnt, 2'b10);

      // Non-owner draw request is dropped and the error sticks.
      r_rdi_ready = 2'b01;
      step();
      r_rdi_ready = 2'b00;
      check("t4_rdi_ready", rdi_ready, 1'b0);
      check("t4_err", protocol_err, 1'b1);
      step();
      step();
      check("t4_err_sticky", protocol_err, 1'b1);

      // Round-robin, both tie directions.
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t2_err_cleared", protocol_err, 1'b0);
      req = 2'b11;
      step();
      check("t2_gnt_a", gnt, 2'b01);
      req = 2'b10;
      step();
      check("t2_gap_a", gnt, 2'b00);
      step();
      check("t2_gnt_b", gnt, 2'b10);
      req = 2'b01;
      step();
      check("t2_gap_b", gnt, 2'b00);
      req = 2'b11;
      step();
      check("t2_tie_0", gnt, 2'b01);
      req = 2'b10;
      step();
      req = 2'b11;
      step();
      check("t2_tie_1", gnt, 2'b10);

      // Owner 1 issues reseed and draw together: only reseed goes out.
      r_reseed = 2'b10;
      r_rdi_ready = 2'b10;
      step();
      r_reseed = 2'b00;
      r_rdi_ready = 2'b00;
      check("t5_reseed", reseed, 1'b1);
      check("t5_rdi_ready", rdi_ready, 1'b0);
      check("t5_seed", seed, SEED1);
      check("t5_err", protocol_err, 1'b1);

      // Reset with a draw outstanding; late responses are ignored.
      r_rdi_ready = 2'b10;
      step();
      r_rdi_ready = 2'b00;
      check("t6_rdi_ready", rdi_ready, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t6_gnt", gnt, 2'b00);
      check("t6_rdi_ready_clr", rdi_ready, 1'b0);
      rdi_valid = 1'b1;
      reseed_ack = 1'b1;
      #1;
      check("t6_late_valid", r_rdi_valid, 2'b00);
      check("t6_late_ack", r_reseed_ack, 2'b00);
      step();
      rdi_valid = 1'b0;
      reseed_ack = 1'b0;

      // Random traffic; odd epochs also inject illegal pulses and stray responses.
      for (int ep = 0; ep < 8; ep++) begin
         r_reseed = 2'b00;
         r_rdi_ready = 2'b00;
         rst = 1'b1;
         step();
         rst = 1'b0;
         for (int c = 0; c < 250; c++) begin
            step();
            reseed_ack = 1'b0;
            rdi_valid = 1'b0;
            if (saw_rs) rs_cnt = $urandom_range(1, 3);
            if (rs_cnt > 0) begin
               rs_cnt--;
               if (rs_cnt == 0) reseed_ack = 1'b1;
            end
            if (saw_rd) rd_cnt = $urandom_range(1, 4);
            if (rd_cnt > 0) begin
               rd_cnt--;
               if (rd_cnt == 0) rdi_valid = 1'b1;
            end
            rdi_data = {$urandom, $urandom, $urandom, $urandom};
            r0_seed = {8{$urandom}};
            r1_seed = {8{$urandom}};
            for (int i = 0; i < 2; i++)
               if ($urandom_range(0, 15) == 0) req[i] = ~req[i];
            r_reseed = 2'b00;
            r_rdi_ready = 2'b00;
            if (ep % 2 == 1) begin
               if ($urandom_range(0, 9) == 0) r_reseed = 2'($urandom_range(1, 3));
               if ($urandom_range(0, 5) == 0) r_rdi_ready = 2'($urandom_range(1, 3));
               if (!m_rs && $urandom_range(0, 29) == 0) reseed_ack = 1'b1;
               if (!m_rd && $urandom_range(0, 29) == 0) rdi_valid = 1'b1;
            end else if (m_holder >= 0) begin
               if (!m_rs && !reseed_ack && $urandom_range(0, 7) == 0) r_reseed[m_holder] = 1'b1;
               else if (!m_rd && !rdi_valid && $urandom_range(0, 3) == 0) r_rdi_ready[m_holder] = 1'b1;
            end
         end
      end
      r_reseed = 2'b00;
      r_rdi_ready = 2'b00;
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
